// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between program_rom and decode.
// Holds the PC, drives the ROM address combinationally from it, and registers
// the returned instruction with its PC for a valid/ready handoff to decode.
// Execute redirects override everything and drop any held instruction.
// Optional build macro: FETCH_PREDECODE_JMP_EN -- when defined, jmp (opcode
// 4'b1000) is resolved here on load and never delivered to decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
);

  logic [ADDR_W-1:0]  pc_q,        pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q,    out_pc_d;

  logic load;
  logic jmp_hit;
  logic [ADDR_W-1:0] jmp_target;

  // The output slot can take a new instruction when it is empty or draining.
  assign load = fetch_en && (!out_valid_q || out_ready);

`ifdef FETCH_PREDECODE_JMP_EN
  assign jmp_hit    = (instruction[INSTR_W-1 -: 4] == 4'b1000);
  assign jmp_target = instruction[INSTR_W-5 -: ADDR_W];
`else
  assign jmp_hit    = 1'b0;
  assign jmp_target = '0;
`endif

  // Next-state selection: redirect, then load (or predecoded jmp), then drain, else hold.
  always_comb begin
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
    end else if (load) begin
      if (jmp_hit) begin
        // jmp consumed at fetch: steer PC, leave a bubble, keep old payload.
        pc_d        = jmp_target;
        out_valid_d = 1'b0;
      end else begin
        out_instr_d = instruction;
        out_pc_d    = pc_q;
        out_valid_d = 1'b1;
        pc_d        = pc_q + 1'b1;
      end
    end else if (out_valid_q && out_ready && !fetch_en) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= ADDR_W'(RESET_PC);
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign address   = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the ROM is modelled as a table, expected deliveries
// are queued by the stimulus and popped by a monitor on each handshake.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fetch_en;
  logic [ADDR_W-1:0]  address;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;

  logic [INSTR_W-1:0] rom [16];

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .address         (address),
    .instruction     (instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  assign instruction = rom[address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [INSTR_W-1:0] instr, input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: got instr %h pc %0d expected none at %0t",
                 out_instr, out_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_instr", 32'(out_instr), 32'(e.instr));
        check("deliver_pc",    32'(out_pc),    32'(e.pc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h2000 | 16'(i << 8) | 16'(i);
    rom[0]  = 16'h1E07;
    rom[1]  = 16'hFE00;
    rom[2]  = 16'h1201;
    rom[3]  = 16'hB401;
    rom[7]  = 16'h8300;
    rom[10] = 16'hF200;

    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    #2;
    check("reset_valid",   32'(out_valid), 32'd0);
    check("reset_instr",   32'(out_instr), 32'd0);
    check("reset_pc",      32'(out_pc),    32'd0);
    check("reset_address", 32'(address),  32'd0);

    // Streaming with out_ready high, then a three-cycle stall on out_pc=2.
    #10;
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    push(16'h1E07, 0); push(16'hFE00, 1); push(16'h1201, 2); push(16'hB401, 3);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_instr", 32'(out_instr), 32'h1E07);
    check("first_pc",    32'(out_pc),    32'd0);
    tick();
    check("second_instr", 32'(out_instr), 32'hFE00);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid",   32'(out_valid), 32'd1);
      check("stall_pc",      32'(out_pc),    32'd2);
      check("stall_instr",   32'(out_instr), 32'h1201);
      check("stall_address", 32'(address),   32'd3);
    end
    out_ready = 1'b1;
    tick();
    check("resume_pc", 32'(out_pc), 32'd3);

    // Redirect to 10 while out_pc=3 is being accepted.
    redirect_valid = 1'b1; redirect_target = 4'd10;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble",  32'(out_valid), 32'd0);
    check("redir_address", 32'(address),   32'd10);
    push(16'hF200, 10);
    tick();
    check("redir_pc",    32'(out_pc),    32'd10);
    check("redir_instr", 32'(out_instr), 32'hF200);

    // Wrap: 14, 15, 0, 1.
    redirect_valid = 1'b1; redirect_target = 4'd14;
    tick();
    redirect_valid = 1'b0;
    push(rom[14], 14); push(rom[15], 15); push(16'h1E07, 0); push(16'hFE00, 1);
    tick();
    tick();
    check("wrap_pc",      32'(out_pc),  32'd15);
    check("wrap_address", 32'(address), 32'd0);
    tick();
    tick();
    check("wrap_pc_after", 32'(out_pc), 32'd1);

    // jmp at ROM[7] reached from 5.
    redirect_valid = 1'b1; redirect_target = 4'd5;
    tick();
    redirect_valid = 1'b0;
    push(rom[5], 5); push(rom[6], 6);
`ifdef FETCH_PREDECODE_JMP_EN
    push(16'hB401, 3); push(rom[4], 4);
`else
    push(16'h8300, 7); push(rom[8], 8); push(rom[9], 9);
`endif
    repeat (4) tick();
`ifdef FETCH_PREDECODE_JMP_EN
    check("jmp_target_pc", 32'(out_pc), 32'd3);
`else
    check("jmp_plain_pc",  32'(out_pc), 32'd8);
`endif
    tick();
`ifdef FETCH_PREDECODE_JMP_EN
    push(16'h0, 0);
    void'(exp_q.pop_back());
`endif

    // Stall at out_pc=5, then asynchronous reset mid-cycle.
    redirect_valid = 1'b1; redirect_target = 4'd5;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("stall5_valid", 32'(out_valid), 32'd1);
    check("stall5_pc",    32'(out_pc),    32'd5);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid",   32'(out_valid), 32'd0);
    check("async_pc",      32'(out_pc),    32'd0);
    check("async_instr",   32'(out_instr), 32'd0);
    check("async_address", 32'(address),   32'd0);
    #2;
    rst_n = 1'b1; out_ready = 1'b1;
    push(16'h1E07, 0); push(16'hFE00, 1);
    tick();
    check("post_reset_pc",    32'(out_pc),    32'd0);
    check("post_reset_valid", 32'(out_valid), 32'd1);
    tick();
    fetch_en = 1'b0;
    tick();
    check("drain_valid",   32'(out_valid), 32'd0);
    check("freeze_address", 32'(address),  32'd2);
    tick();
    check("freeze_address2", 32'(address), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
